// File: rtl/mesm6_mem_arbiter_pkg.sv
// Shared types and defaults for the mesm6 instruction/data memory arbiter.
package mesm6_mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W  = 15;
  localparam int unsigned ARB_DATA_W  = 48;
  localparam int unsigned ARB_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_D_ACC = 2'd1,
    ARB_I_ACC = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  // Request flags sampled in IDLE and held for the whole request pair
  typedef struct packed {
    logic need_d;
    logic need_i;
    logic we;
  } arb_req_t;

endpackage

// File: rtl/mesm6_mem_arbiter.sv
// Serialises core ibus/dbus requests onto one single-port memory, data first,
// returning both done pulses together when a fetch and data access are joined.
module mesm6_mem_arbiter
  import mesm6_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  // Counter must be able to hold TIMEOUT itself
  localparam int unsigned WDOG_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t        r_state, w_state_nxt;
  arb_req_t          r_req, w_req_nxt;
  logic [ADDR_W-1:0] r_iaddr, w_iaddr_nxt, r_daddr, w_daddr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;

  logic              r_mem_req, w_mem_req_nxt, r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_ibus_input, w_ibus_input_nxt, r_dbus_input, w_dbus_input_nxt;
  logic              r_ibus_done, w_ibus_done_nxt, r_dbus_done, w_dbus_done_nxt;
  logic              r_bus_err, w_bus_err_nxt;

  logic w_acc, w_expire, w_fin, w_conflict;

  assign w_acc      = (r_state == ARB_D_ACC) || (r_state == ARB_I_ACC);
  assign w_expire   = (TIMEOUT != 0) && (r_wdog == WDOG_W'(TIMEOUT));
  assign w_fin      = w_acc && (mem_ack || w_expire);
  assign w_conflict = dbus_read && dbus_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ARB_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (dbus_read || dbus_write) w_state_nxt = ARB_D_ACC;
        else if (ibus_fetch)         w_state_nxt = ARB_I_ACC;
      end
      ARB_D_ACC: if (w_fin) w_state_nxt = r_req.need_i ? ARB_I_ACC : ARB_DONE;
      ARB_I_ACC: if (w_fin) w_state_nxt = ARB_DONE;
      ARB_DONE:  w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Next values of every registered output, derived from the state being entered
  always_comb begin
    w_req_nxt   = r_req;
    w_iaddr_nxt = r_iaddr;
    w_daddr_nxt = r_daddr;
    w_wdata_nxt = r_wdata;
    if (r_state == ARB_IDLE) begin
      w_req_nxt.need_d = dbus_read | dbus_write;
      w_req_nxt.need_i = ibus_fetch;
      w_req_nxt.we     = dbus_write;
      w_iaddr_nxt      = ibus_addr;
      w_daddr_nxt      = dbus_addr;
      w_wdata_nxt      = dbus_output;
    end

    w_wdog_nxt = (!w_acc || w_fin) ? '0 : r_wdog + WDOG_W'(1);

    w_mem_req_nxt   = (w_state_nxt == ARB_D_ACC) || (w_state_nxt == ARB_I_ACC);
    w_mem_we_nxt    = (w_state_nxt == ARB_D_ACC) && w_req_nxt.we;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    if (w_state_nxt == ARB_D_ACC) begin
      w_mem_addr_nxt  = w_daddr_nxt;
      w_mem_wdata_nxt = w_wdata_nxt;
    end else if (w_state_nxt == ARB_I_ACC) begin
      w_mem_addr_nxt = w_iaddr_nxt;
    end

    w_ibus_done_nxt = (w_state_nxt == ARB_DONE) && w_req_nxt.need_i;
    w_dbus_done_nxt = (w_state_nxt == ARB_DONE) && w_req_nxt.need_d;

    // A watchdog-forced completion returns zero instead of stale bus data
    w_ibus_input_nxt = r_ibus_input;
    if ((r_state == ARB_I_ACC) && w_fin) w_ibus_input_nxt = mem_ack ? mem_rdata : '0;
    w_dbus_input_nxt = r_dbus_input;
    if ((r_state == ARB_D_ACC) && w_fin && !r_req.we)
      w_dbus_input_nxt = mem_ack ? mem_rdata : '0;

    w_bus_err_nxt = r_bus_err || (w_fin && !mem_ack) || ((r_state == ARB_IDLE) && w_conflict);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req   <= '0;
      r_iaddr <= '0;
      r_daddr <= '0;
      r_wdata <= '0;
      r_wdog  <= '0;
    end else begin
      r_req   <= w_req_nxt;
      r_iaddr <= w_iaddr_nxt;
      r_daddr <= w_daddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ibus_input <= '0;
      r_dbus_input <= '0;
      r_ibus_done  <= 1'b0;
      r_dbus_done  <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_ibus_input <= w_ibus_input_nxt;
      r_dbus_input <= w_dbus_input_nxt;
      r_ibus_done  <= w_ibus_done_nxt;
      r_dbus_done  <= w_dbus_done_nxt;
      r_bus_err    <= w_bus_err_nxt;
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign ibus_input = r_ibus_input;
  assign dbus_input = r_dbus_input;
  assign ibus_done  = r_ibus_done;
  assign dbus_done  = r_dbus_done;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Randomised self-checking bench for mesm6_mem_arbiter with a wait-state memory responder.
module tb_mesm6_mem_arbiter;

  logic        clk, reset_n;
  logic        ibus_fetch, ibus_done, dbus_read, dbus_write, dbus_done;
  logic [14:0] ibus_addr, dbus_addr, mem_addr;
  logic [47:0] ibus_input, dbus_input, dbus_output, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ack, bus_err;

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic        we;
    logic [47:0] wdata;
  } rec_t;

  rec_t        req_log[$];
  rec_t        txn_q[$];
  int          wait_q[$];
  logic [47:0] mem[int];
  bit          ack_en;
  int          cyc;
  int          n_cmp, n_fail;
  logic [47:0] exp_ibus_in, exp_dbus_in;

  mesm6_mem_arbiter #(.ADDR_W(15), .DATA_W(48), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: acks after the queued number of wait cycles, in the same cycle at zero wait
  initial begin
    int   waited, cur_wait;
    bit   in_txn;
    rec_t rec;
    waited = 0; cur_wait = 0; in_txn = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!mem_req) in_txn = 0;
      else begin
        if (!in_txn) begin
          in_txn = 1; waited = 0;
          cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        rec.cyc = cyc; rec.addr = mem_addr; rec.we = mem_we; rec.wdata = mem_wdata;
        req_log.push_back(rec);
        if (ack_en && waited >= cur_wait) begin
          mem_ack = 1'b1;
          if (mem_we) mem[int'(mem_addr)] = mem_wdata;
          else mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : '0;
          txn_q.push_back(rec);
          in_txn = 0;
        end else waited++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ibus_fetch = 0; dbus_read = 0; dbus_write = 0;
    wait_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick();
    exp_ibus_in = '0; exp_dbus_in = '0;
  endtask

  // Drives one request set until the first done pulse (40-cycle bound), then drops it
  task automatic issue(input logic f, r, w, input logic [14:0] ia, da, input logic [47:0] wd,
                       output int done_cyc, output logic i_d, d_d, output int extra);
    done_cyc = -1; i_d = 0; d_d = 0; extra = 0;
    ibus_fetch = f; dbus_read = r; dbus_write = w;
    ibus_addr = ia; dbus_addr = da; dbus_output = wd;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      tick();
      if (ibus_done || dbus_done) begin done_cyc = k; i_d = ibus_done; d_d = dbus_done; end
    end
    ibus_fetch = 0; dbus_read = 0; dbus_write = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ibus_done || dbus_done) extra++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ack_en = 1;
    ibus_fetch = 0; dbus_read = 0; dbus_write = 0;
    ibus_addr = '0; dbus_addr = '0; dbus_output = '0;
    #3;
    n_cmp++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    do_reset();
    n_cmp++;
    if ({mem_req, mem_we, ibus_done, dbus_done, bus_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {mem_req, mem_we, ibus_done, dbus_done, bus_err});
    end
    n_cmp++;
    if ({ibus_input, dbus_input, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {ibus_input, dbus_input, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_lone_fetch();
    int dc, ex, t0; logic id, dd;
    mem[8] = 48'h123456789ABC;
    req_log.delete(); txn_q.delete();
    t0 = cyc;
    issue(1, 0, 0, 15'o00010, 15'd0, 48'd0, dc, id, dd, ex);
    exp_ibus_in = 48'h123456789ABC;
    n_cmp++;
    if (dc !== 2) begin n_fail++; $display("FAIL fetch_done_cycle: got %0d want 2", dc); end
    n_cmp++;
    if ({id, dd, ex[1:0]} !== 4'b1000) begin n_fail++; $display("FAIL fetch_done_flags: got %b%b extra %0d want 10 extra 0", id, dd, ex); end
    n_cmp++;
    if (ibus_input !== exp_ibus_in) begin n_fail++; $display("FAIL fetch_data: got %h want %h", ibus_input, exp_ibus_in); end
    n_cmp++;
    if (req_log.size() != 1 || req_log[0].cyc != t0 + 1 || req_log[0].addr !== 15'o00010 || req_log[0].we !== 1'b0) begin
      n_fail++; $display("FAIL fetch_mem_req: got %0d req cycles want 1 at cycle 1 addr 8 read", req_log.size());
    end
  endtask

  task automatic test_data_write();
    int dc, ex, bad; logic id, dd;
    req_log.delete(); txn_q.delete();
    wait_q.push_back(3);
    issue(0, 0, 1, 15'd0, 15'o1234, 48'hFFFF00000001, dc, id, dd, ex);
    n_cmp++;
    if (dc !== 5) begin n_fail++; $display("FAIL write_done_cycle: got %0d want 5", dc); end
    n_cmp++;
    if ({id, dd, ex[1:0]} !== 4'b0100) begin n_fail++; $display("FAIL write_done_flags: got %b%b extra %0d want 01 extra 0", id, dd, ex); end
    bad = 0;
    foreach (req_log[i])
      if (req_log[i].addr !== 15'o1234 || req_log[i].we !== 1'b1 || req_log[i].wdata !== 48'hFFFF00000001) bad++;
    n_cmp++;
    if (req_log.size() != 4 || bad != 0) begin
      n_fail++; $display("FAIL write_stable: got %0d req cycles, %0d unstable want 4, 0", req_log.size(), bad);
    end
    n_cmp++;
    if (dbus_input !== exp_dbus_in) begin n_fail++; $display("FAIL write_dbus_input: got %h want %h", dbus_input, exp_dbus_in); end
    n_cmp++;
    if (mem[int'(15'o1234)] !== 48'hFFFF00000001) begin n_fail++; $display("FAIL write_mem: got %h want ffff00000001", mem[int'(15'o1234)]); end
  endtask

  task automatic test_joined();
    int dc, ex; logic id, dd;
    mem[5] = 48'hA; mem[6] = 48'hB;
    txn_q.delete();
    issue(1, 1, 0, 15'd6, 15'd5, 48'd0, dc, id, dd, ex);
    exp_ibus_in = 48'hB; exp_dbus_in = 48'hA;
    n_cmp++;
    if (dc !== 3 || {id, dd} !== 2'b11) begin n_fail++; $display("FAIL joined_done: got cycle %0d flags %b%b want 3 11", dc, id, dd); end
    n_cmp++;
    if (txn_q.size() != 2 || txn_q[0].addr !== 15'd5 || txn_q[1].addr !== 15'd6) begin
      n_fail++; $display("FAIL joined_order: got %0d txns want addr 5 then 6", txn_q.size());
    end
    n_cmp++;
    if (dbus_input !== exp_dbus_in || ibus_input !== exp_ibus_in) begin
      n_fail++; $display("FAIL joined_data: got d=%h i=%h want d=a i=b", dbus_input, ibus_input);
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    logic [47:0] v;
    v = {16'($urandom), 32'($urandom)} | 48'h1;
    mem[9] = v;
    txn_q.delete();
    dbus_read = 1; dbus_addr = 15'd9;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (dbus_done) pulses.push_back(k);
      if (k == 4) dbus_read = 0;
    end
    exp_dbus_in = v;
    n_cmp++;
    if (txn_q.size() != 2) begin n_fail++; $display("FAIL b2b_txn_count: got %0d want 2", txn_q.size()); end
    n_cmp++;
    if (pulses.size() != 2 || pulses[0] != 2 || pulses[1] != 5) begin
      n_fail++; $display("FAIL b2b_done_cycles: got %0d pulses want 2 at cycles 2 and 5", pulses.size());
    end
    n_cmp++;
    if (dbus_input !== exp_dbus_in) begin n_fail++; $display("FAIL b2b_data: got %h want %h", dbus_input, exp_dbus_in); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int mode, wd, wi, dc, ex, lat, ntx;
      logic f, r, w, id, dd;
      logic [14:0] ia, da;
      logic [47:0] iv, dv, wdat, exp_i, exp_d;
      mode = $urandom_range(0, 4);
      f = (mode == 0 || mode >= 3); r = (mode == 1 || mode == 3); w = (mode == 2 || mode == 4);
      ia = 15'($urandom);
      da = ($urandom_range(0, 3) == 0) ? ia : 15'($urandom);
      iv = {16'($urandom), 32'($urandom)}; dv = {16'($urandom), 32'($urandom)};
      wdat = {16'($urandom), 32'($urandom)};
      mem[int'(ia)] = iv; mem[int'(da)] = dv;
      wd = $urandom_range(0, 4); wi = $urandom_range(0, 4);
      wait_q.delete();
      if (r || w) wait_q.push_back(wd);
      if (f) wait_q.push_back(wi);
      // Data access first, then the fetch, then one done cycle
      lat   = 1 + ((r || w) ? wd + 1 : 0) + (f ? wi + 1 : 0);
      ntx   = ((r || w) ? 1 : 0) + (f ? 1 : 0);
      exp_d = r ? dv : exp_dbus_in;
      exp_i = !f ? exp_ibus_in : (w && da == ia) ? wdat : (da == ia) ? dv : iv;
      txn_q.delete();
      issue(f, r, w, ia, da, wdat, dc, id, dd, ex);
      n_cmp++;
      if (dc != lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, dc, lat); end
      n_cmp++;
      if ({id, dd} !== {f, r | w} || ex != 0) begin
        n_fail++; $display("FAIL rnd%0d_flags: got %b%b extra %0d want %b%b extra 0", it, id, dd, ex, f, r | w);
      end
      n_cmp++;
      if (ibus_input !== exp_i) begin n_fail++; $display("FAIL rnd%0d_ibus: got %h want %h", it, ibus_input, exp_i); end
      n_cmp++;
      if (dbus_input !== exp_d) begin n_fail++; $display("FAIL rnd%0d_dbus: got %h want %h", it, dbus_input, exp_d); end
      n_cmp++;
      if (txn_q.size() != ntx) begin n_fail++; $display("FAIL rnd%0d_txns: got %0d want %0d", it, txn_q.size(), ntx); end
      exp_ibus_in = exp_i; exp_dbus_in = exp_d;
    end
    n_cmp++;
    if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rnd_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_conflict();
    int dc, ex; logic id, dd;
    txn_q.delete();
    issue(0, 1, 1, 15'd0, 15'd100, 48'h0000CAFE0001, dc, id, dd, ex);
    n_cmp++;
    if (dc !== 2 || dd !== 1'b1 || txn_q.size() != 1 || txn_q[0].we !== 1'b1) begin
      n_fail++; $display("FAIL conflict_as_write: got cycle %0d txns %0d want cycle 2 one write", dc, txn_q.size());
    end
    n_cmp++;
    if (bus_err !== 1'b1 || dbus_input !== exp_dbus_in) begin
      n_fail++; $display("FAIL conflict_err: got err %b dbus %h want 1 %h", bus_err, dbus_input, exp_dbus_in);
    end
  endtask

  task automatic test_watchdog();
    int dc, ex; logic id, dd;
    do_reset();
    mem[20] = 48'h55AA55AA55AA;
    issue(0, 1, 0, 15'd0, 15'd20, 48'd0, dc, id, dd, ex);
    exp_dbus_in = 48'h55AA55AA55AA;
    n_cmp++;
    if (dbus_input !== exp_dbus_in) begin n_fail++; $display("FAIL wdog_preload: got %h want %h", dbus_input, exp_dbus_in); end
    ack_en = 0; mem_rdata = 48'hBAD0BAD0BAD0;
    req_log.delete();
    issue(0, 1, 0, 15'd0, 15'd21, 48'd0, dc, id, dd, ex);
    exp_dbus_in = '0;
    n_cmp++;
    if (dc !== 10 || dd !== 1'b1) begin n_fail++; $display("FAIL wdog_done: got cycle %0d flag %b want 10 1", dc, dd); end
    n_cmp++;
    if (dbus_input !== '0 || bus_err !== 1'b1) begin
      n_fail++; $display("FAIL wdog_result: got dbus %h err %b want 0 1", dbus_input, bus_err);
    end
    n_cmp++;
    if (req_log.size() != 9) begin n_fail++; $display("FAIL wdog_req_cycles: got %0d want 9", req_log.size()); end
    ack_en = 1;
    mem[22] = 48'h777;
    issue(1, 0, 0, 15'd22, 15'd0, 48'd0, dc, id, dd, ex);
    n_cmp++;
    if (bus_err !== 1'b1 || ibus_input !== 48'h777) begin
      n_fail++; $display("FAIL wdog_sticky: got err %b ibus %h want 1 777", bus_err, ibus_input);
    end
  endtask

  task automatic test_reset_mid_access();
    int dones, reqs;
    ack_en = 0;
    dbus_read = 1; dbus_addr = 15'd30;
    tick(); tick(); tick();
    n_cmp++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_before: got %b want 1", mem_req); end
    reset_n = 0; dbus_read = 0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop: got %b want 0", mem_req); end
    tick(); tick();
    reset_n = 1;
    tick();
    mem_ack = 1'b1;
    ack_en = 1;
    dones = 0; reqs = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ibus_done || dbus_done) dones++;
      if (mem_req) reqs++;
    end
    n_cmp++;
    if (dones != 0 || reqs != 0) begin n_fail++; $display("FAIL mid_late_ack: got %0d dones %0d reqs want 0 0", dones, reqs); end
    n_cmp++;
    if (bus_err !== 1'b0 || dbus_input !== '0) begin
      n_fail++; $display("FAIL mid_state: got err %b dbus %h want 0 0", bus_err, dbus_input);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    exp_ibus_in = '0; exp_dbus_in = '0;
    test_reset();
    test_lone_fetch();
    test_data_write();
    test_joined();
    test_back_to_back();
    test_random();
    test_conflict();
    test_watchdog();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
